outport_vc_arbiter: RTL and testbench
=====================================

Name: outport_vc_arbiter

Overview:
- Per-output-port arbitration and credit manager for the chiplet switch.
- Selects one of NUM_INPORTS input buffers for one output link and tracks downstream credits per virtual channel.
- Holds a wormhole lock until the packet's tail flit has been sent.
- One instance per switch output port. Generalises the switch's flat data_ready/credit_granted/packet_sent handshake with configurable port and VC counts, per-VC credit depth, and packet locking.

Parameters:
- NUM_INPORTS, 4, number of input buffers competing for this output.
- NUM_VCS, 2, virtual channels on the output link.
- CREDIT_DEPTH, 8, downstream buffer slots per VC; initial and maximum credit count.
- VC_W, $clog2(NUM_VCS) (minimum 1), VC index width (derived).
- CREDIT_W, $clog2(CREDIT_DEPTH+1), credit counter width (derived).

Ports:
- clk  in  1  single clock, rising edge.
- n_rst  in  1  synchronous active-low reset.
- req_valid  in  NUM_INPORTS  input i has a flit at its buffer head.
- req_flit  in  NUM_INPORTS x flit_t  head flit per input.
- req_vc  in  NUM_INPORTS x VC_W  destination VC of the head flit.
- req_last  in  NUM_INPORTS  head flit is a packet tail (single-flit packets have last=1).
- grant  out  NUM_INPORTS  one-hot, combinational; input i's head flit is consumed this cycle.
- out  out  flit_t  registered output flit.
- out_vc  out  VC_W  VC of out.
- data_ready_out  out  1  out/out_vc valid this cycle.
- credit_granted  in  NUM_VCS  one-cycle credit-return pulse per VC from downstream.
- packet_sent  out  1  pulses together with data_ready_out when the flit was a tail.
- credit_count  out  NUM_VCS x CREDIT_W  current credits (observability).
- locked  out  1  a packet is mid-transfer.
- credit_overflow  out  1  sticky error: a credit was returned while the count was already CREDIT_DEPTH.

Behaviour:
- Reset (n_rst=0 at posedge):
  - out, out_vc, data_ready_out, packet_sent, locked, credit_overflow = 0.
  - every credit_count = CREDIT_DEPTH.
  - rr_ptr = 0; state = IDLE.
  - grant is held 0 while n_rst=0.
- Reset mid-packet discards the lock; no flush of in-flight flits.
- Eligibility: eligible[i] = req_valid[i] && credit_count[req_vc[i]] != 0.
- IDLE state:
  - Round-robin over eligible, starting at rr_ptr and wrapping at NUM_INPORTS-1 -> 0.
  - On a winner w: grant[w] = 1 and the flit is sent.
  - If req_last[w]=0: next state = LOCKED, owner = w, lock_vc = req_vc[w].
  - If req_last[w]=1: stay IDLE.
  - rr_ptr = (w+1) mod NUM_INPORTS whenever a tail is sent.
- LOCKED state:
  - Only the owner is considered. grant[owner] = 1 iff req_valid[owner] && credit_count[lock_vc] != 0.
  - Other inputs stall even if their credits are available.
  - On a sent flit with req_last=1: next state = IDLE, rr_ptr = owner+1.
  - An owner bubble (req_valid=0) holds the lock indefinitely.
  - req_vc[owner] != lock_vc is a protocol error: simulation assertion; RTL uses lock_vc.
- Latency:
  - grant in cycle N.
  - out, out_vc, data_ready_out, packet_sent registered in cycle N+1.
  - data_ready_out = 0 in any cycle following no grant.
  - Maximum throughput is one flit per cycle.
- Credits, per VC v, updated at each posedge:
  - send on v only: -1.
  - credit_granted[v] only: +1.
  - both: unchanged.
  - A send is never issued at 0 (eligibility guarantees it).
  - An increment at CREDIT_DEPTH is dropped and sets credit_overflow, which stays set until reset.
- Credit timing: a credit returned in cycle N affects eligibility in cycle N+1 (no bypass). A flit granted at credit 1 blocks that VC in N+1 unless a credit also returned in N.
- locked mirrors state == LOCKED.

Decomposition:
- chiplet_types_pkg holds:
  - flit_t (existing).
  - new arb_state_t enum {ARB_IDLE, ARB_LOCKED}.
  - default constants DEF_NUM_VCS=2, DEF_CREDIT_DEPTH=8.
- Sub-module rr_arbiter #(N):
  - inputs: request vector, rr_ptr.
  - outputs: one-hot grant, winner index, any_grant.
  - purely combinational.
  - reused by the switch's VC allocator.
- Credit counters stay inline (generate loop over NUM_VCS).

Test Plan:
- Reset then idle:
  - Stimulus: reset, then hold req_valid=0 for 5 cycles.
  - Required: credit_count={8,8}, data_ready_out=0, grant=0, locked=0 throughout.
- Round-robin fairness:
  - Stimulus: inputs 0–3 each offer single-flit packets on VC0 continuously, with a credit returned every cycle.
  - Required: grants in order 0,1,2,3,0; data_ready_out high every cycle from cycle 2 on; packet_sent high with each flit.
- Wormhole lock:
  - Stimulus: input 1 sends a 3-flit packet on VC1 while input 2 requests VC0 throughout.
  - Required: grant[1] for 3 consecutive cycles and locked=1 during them; grant[2] in the cycle after the tail; packet_sent only on the tail.
- Credit exhaustion and return:
  - Stimulus: CREDIT_DEPTH=8, no credits returned, input 0 streams 10 flits on VC0.
  - Required: exactly 8 grants then stall with credit_count[0]=0. A credit_granted[0] pulse in cycle N gives grant in N+1 and credit_count returns to 0.
- Simultaneous send and return:
  - Stimulus: credit_count[1]=3; in the same cycle send on VC1 and pulse credit_granted[1].
  - Required: credit_count[1] stays 3. Then with count 8 and no send, a return sets credit_overflow=1, count stays 8, and overflow stays set.
- Reset mid-packet:
  - Stimulus: assert n_rst=0 after the 2nd flit of a 4-flit packet from input 3.
  - Required: next cycle locked=0, credits={8,8}, data_ready_out=0. After release, input 0 wins over input 3 (rr_ptr=0).

Source files
------------

// File: rtl/chiplet_types_pkg.sv
// Shared chiplet switch types: flit format, output-arbiter state encoding and
// default link dimensions.
package chiplet_types_pkg;

    localparam int FLIT_W           = 32;
    localparam int DEF_NUM_VCS      = 2;
    localparam int DEF_CREDIT_DEPTH = 8;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Index width for n items, never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/outport_vc_arbiter_chk.sv
// Protocol checker: a locked owner must keep presenting the VC it locked on.
module outport_vc_arbiter_chk #(
    parameter int VC_W = 1
) (
    input logic            clk,
    input logic            n_rst,
    input logic            chk_en,
    input logic [VC_W-1:0] owner_vc,
    input logic [VC_W-1:0] lock_vc
);

    a_owner_vc_stable: assert property (@(posedge clk) disable iff (!n_rst)
        chk_en |-> (owner_vc == lock_vc));

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after ptr_i
// wins, wrapping from N-1 back to 0.
module rr_arbiter
    import chiplet_types_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // Scan candidates in priority order starting from the pointer.
    always_comb begin
        int c;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        c     = 0;
        for (int k = 0; k < N; k++) begin
            c = (int'(ptr_i) + k) % N;
            if (!any_o && req_i[c]) begin
                any_o    = 1'b1;
                idx_o    = IW'(c);
                gnt_o[c] = 1'b1;
            end else begin
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/outport_vc_arbiter.sv
// Output-port arbiter: round-robin input selection, wormhole packet locking and
// per-VC downstream credit tracking with a registered output flit.
module outport_vc_arbiter
    import chiplet_types_pkg::*;
#(
    parameter int NUM_INPORTS  = 4,
    parameter int NUM_VCS      = DEF_NUM_VCS,
    parameter int CREDIT_DEPTH = DEF_CREDIT_DEPTH,
    parameter int VC_W         = idx_width(NUM_VCS),
    parameter int CREDIT_W     = $clog2(CREDIT_DEPTH + 1)
) (
    input  logic                                 clk,
    input  logic                                 n_rst,
    input  logic [NUM_INPORTS-1:0]               req_valid,
    input  flit_t [NUM_INPORTS-1:0]              req_flit,
    input  logic [NUM_INPORTS-1:0][VC_W-1:0]     req_vc,
    input  logic [NUM_INPORTS-1:0]               req_last,
    output logic [NUM_INPORTS-1:0]               grant,
    output flit_t                                out,
    output logic [VC_W-1:0]                      out_vc,
    output logic                                 data_ready_out,
    input  logic [NUM_VCS-1:0]                   credit_granted,
    output logic                                 packet_sent,
    output logic [NUM_VCS-1:0][CREDIT_W-1:0]     credit_count,
    output logic                                 locked,
    output logic                                 credit_overflow
);

    localparam int IDX_W = idx_width(NUM_INPORTS);

    arb_state_t                         state_q;
    logic [IDX_W-1:0]                   rr_ptr_q, owner_q;
    logic [VC_W-1:0]                    lock_vc_q;
    flit_t                              out_q;
    logic [VC_W-1:0]                    out_vc_q;
    logic                               data_ready_q, packet_sent_q, overflow_q;
    logic [NUM_VCS-1:0][CREDIT_W-1:0]   credit_s;
    logic [NUM_VCS-1:0]                 ovf_hit_s;
    logic [NUM_INPORTS-1:0]             eligible_s, rr_gnt_s;
    logic [IDX_W-1:0]                   rr_idx_s, send_idx_s, next_ptr_s;
    logic                               rr_any_s, send_s, send_last_s;
    logic [VC_W-1:0]                    send_vc_s;

    // An input may compete only if its target VC has at least one credit.
    always_comb begin
        eligible_s = '0;
        for (int i = 0; i < NUM_INPORTS; i++) begin
            eligible_s[i] = req_valid[i] && (credit_s[req_vc[i]] != '0);
        end
    end

    rr_arbiter #(.N(NUM_INPORTS), .IW(IDX_W)) u_rr (
        .req_i (eligible_s),
        .ptr_i (rr_ptr_q),
        .gnt_o (rr_gnt_s),
        .idx_o (rr_idx_s),
        .any_o (rr_any_s)
    );

    // Select the sender: round-robin when idle, only the owner while locked.
    always_comb begin
        grant       = '0;
        send_s      = 1'b0;
        send_last_s = 1'b0;
        send_idx_s  = rr_idx_s;
        send_vc_s   = req_vc[rr_idx_s];
        if (!n_rst) begin
            grant = '0;
        end else if (state_q == ARB_LOCKED) begin
            send_idx_s = owner_q;
            send_vc_s  = lock_vc_q;
            if (req_valid[owner_q] && (credit_s[lock_vc_q] != '0)) begin
                grant[owner_q] = 1'b1;
                send_s         = 1'b1;
                send_last_s    = req_last[owner_q];
            end else begin
                send_s = 1'b0;
            end
        end else begin
            grant       = rr_gnt_s;
            send_s      = rr_any_s;
            send_last_s = rr_any_s && req_last[rr_idx_s];
        end
    end

    assign next_ptr_s = (send_idx_s == IDX_W'(NUM_INPORTS - 1)) ? '0 : send_idx_s + IDX_W'(1);

    for (genvar v = 0; v < NUM_VCS; v++) begin : g_credit
        logic [CREDIT_W-1:0] cnt_q;
        logic                dec_s, inc_s;

        assign dec_s        = send_s && (send_vc_s == VC_W'(v));
        assign inc_s        = credit_granted[v];
        assign ovf_hit_s[v] = inc_s && !dec_s && (cnt_q == CREDIT_W'(CREDIT_DEPTH));
        assign credit_s[v]  = cnt_q;

        // Credit counter; a return that lands on a full counter is discarded.
        always_ff @(posedge clk) begin
            if (!n_rst) begin
                cnt_q <= CREDIT_W'(CREDIT_DEPTH);
            end else if (dec_s && !inc_s) begin
                cnt_q <= cnt_q - CREDIT_W'(1);
            end else if (inc_s && !dec_s && !ovf_hit_s[v]) begin
                cnt_q <= cnt_q + CREDIT_W'(1);
            end else begin
                cnt_q <= cnt_q;
            end
        end
    end

    // Lock FSM, round-robin pointer, output register and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q       <= ARB_IDLE;
            rr_ptr_q      <= '0;
            owner_q       <= '0;
            lock_vc_q     <= '0;
            out_q         <= '0;
            out_vc_q      <= '0;
            data_ready_q  <= 1'b0;
            packet_sent_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            data_ready_q  <= send_s;
            packet_sent_q <= send_s && send_last_s;
            if (send_s) begin
                out_q    <= req_flit[send_idx_s];
                out_vc_q <= send_vc_s;
            end
            if (|ovf_hit_s) begin
                overflow_q <= 1'b1;
            end
            if (send_s && send_last_s) begin
                rr_ptr_q <= next_ptr_s;
            end
            case (state_q)
                ARB_IDLE: begin
                    if (send_s && !send_last_s) begin
                        state_q   <= ARB_LOCKED;
                        owner_q   <= send_idx_s;
                        lock_vc_q <= send_vc_s;
                    end
                end
                ARB_LOCKED: begin
                    if (send_s && send_last_s) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign out             = out_q;
    assign out_vc          = out_vc_q;
    assign data_ready_out  = data_ready_q;
    assign packet_sent     = packet_sent_q;
    assign credit_count    = credit_s;
    assign locked          = (state_q == ARB_LOCKED);
    assign credit_overflow = overflow_q;

    outport_vc_arbiter_chk #(.VC_W(VC_W)) u_chk (
        .clk      (clk),
        .n_rst    (n_rst),
        .chk_en   ((state_q == ARB_LOCKED) && req_valid[owner_q]),
        .owner_vc (req_vc[owner_q]),
        .lock_vc  (lock_vc_q)
    );

endmodule

// File: tb/tb_outport_vc_arbiter.sv
// Directed bench for outport_vc_arbiter: expected output flits are queued when a
// grant is expected and compared when the registered output appears.
module tb_outport_vc_arbiter;
    import chiplet_types_pkg::*;

    localparam int NI = 4;
    localparam int NV = 2;
    localparam int CW = 4;

    logic                    clk;
    logic                    n_rst;
    logic [NI-1:0]           req_valid;
    flit_t [NI-1:0]          req_flit;
    logic [NI-1:0][0:0]      req_vc;
    logic [NI-1:0]           req_last;
    logic [NI-1:0]           grant;
    flit_t                   out;
    logic [0:0]              out_vc;
    logic                    data_ready_out;
    logic [NV-1:0]           credit_granted;
    logic                    packet_sent;
    logic [NV-1:0][CW-1:0]   credit_count;
    logic                    locked;
    logic                    credit_overflow;

    typedef struct {
        logic       valid;
        flit_t      flit;
        logic [0:0] vc;
        logic       last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   seq    = 0;

    outport_vc_arbiter #(.NUM_INPORTS(NI), .NUM_VCS(NV), .CREDIT_DEPTH(8)) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .req_valid       (req_valid),
        .req_flit        (req_flit),
        .req_vc          (req_vc),
        .req_last        (req_last),
        .grant           (grant),
        .out             (out),
        .out_vc          (out_vc),
        .data_ready_out  (data_ready_out),
        .credit_granted  (credit_granted),
        .packet_sent     (packet_sent),
        .credit_count    (credit_count),
        .locked          (locked),
        .credit_overflow (credit_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic vc, input logic last);
        seq++;
        req_valid[i] = v;
        req_vc[i]    = vc;
        req_last[i]  = last;
        req_flit[i]  = {8'(i), seq[23:0]};
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NI; i++) set_req(i, 1'b0, 1'b0, 1'b0);
    endtask

    // One cycle: check grant, queue expected output, advance, compare output.
    task automatic tick(input logic [NI-1:0] exp_gnt, input string tag);
        exp_t e;
        #1;
        check($sformatf("%s.grant", tag), 64'(grant), 64'(exp_gnt));
        e.valid = (exp_gnt != '0);
        e.flit  = '0;
        e.vc    = 1'b0;
        e.last  = 1'b0;
        for (int i = 0; i < NI; i++) begin
            if (exp_gnt[i]) begin
                e.flit = req_flit[i];
                e.vc   = req_vc[i];
                e.last = req_last[i];
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check($sformatf("%s.data_ready", tag), 64'(data_ready_out), 64'(e.valid));
        check($sformatf("%s.packet_sent", tag), 64'(packet_sent), 64'(e.valid && e.last));
        if (e.valid) begin
            check($sformatf("%s.out", tag), 64'(out), 64'(e.flit));
            check($sformatf("%s.out_vc", tag), 64'(out_vc), 64'(e.vc));
        end
    endtask

    initial begin
        logic [NI-1:0] g;
        n_rst          = 1'b0;
        credit_granted = '0;
        clear_reqs();

        // Reset then idle
        tick(4'b0000, "rst0");
        tick(4'b0000, "rst1");
        n_rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick(4'b0000, "idle");
            check("idle.cc0", 64'(credit_count[0]), 64'd8);
            check("idle.cc1", 64'(credit_count[1]), 64'd8);
            check("idle.locked", 64'(locked), 64'd0);
        end

        // Round-robin fairness with a credit returned every cycle
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < NI; i++) set_req(i, 1'b1, 1'b0, 1'b1);
            credit_granted = 2'b01;
            g = 4'b0001 << (c % 4);
            tick(g, "rr");
        end
        check("rr.cc0", 64'(credit_count[0]), 64'd8);
        check("rr.ovf", 64'(credit_overflow), 64'd0);
        credit_granted = 2'b00;
        clear_reqs();

        // Wormhole lock: input 1 sends 3 flits on VC1, input 2 waits on VC0
        set_req(2, 1'b1, 1'b0, 1'b1);
        set_req(1, 1'b1, 1'b1, 1'b0);
        tick(4'b0010, "wh1");
        check("wh1.locked", 64'(locked), 64'd1);
        set_req(1, 1'b1, 1'b1, 1'b0);
        tick(4'b0010, "wh2");
        check("wh2.locked", 64'(locked), 64'd1);
        set_req(1, 1'b1, 1'b1, 1'b1);
        tick(4'b0010, "wh3");
        check("wh3.locked", 64'(locked), 64'd0);
        set_req(1, 1'b0, 1'b0, 1'b0);
        tick(4'b0100, "wh4");
        check("wh.cc0", 64'(credit_count[0]), 64'd7);
        check("wh.cc1", 64'(credit_count[1]), 64'd5);
        clear_reqs();

        // Refill both VCs
        credit_granted = 2'b11;
        tick(4'b0000, "refill");
        credit_granted = 2'b10;
        tick(4'b0000, "refill");
        tick(4'b0000, "refill");
        credit_granted = 2'b00;
        check("refill.cc0", 64'(credit_count[0]), 64'd8);
        check("refill.cc1", 64'(credit_count[1]), 64'd8);

        // Credit exhaustion on VC0, then a single return
        for (int c = 0; c < 8; c++) begin
            set_req(0, 1'b1, 1'b0, 1'b1);
            tick(4'b0001, "exh");
        end
        check("exh.cc0", 64'(credit_count[0]), 64'd0);
        tick(4'b0000, "exh.stall");
        tick(4'b0000, "exh.stall");
        credit_granted = 2'b01;
        tick(4'b0000, "exh.ret");
        check("exh.ret.cc0", 64'(credit_count[0]), 64'd1);
        credit_granted = 2'b00;
        set_req(0, 1'b1, 1'b0, 1'b1);
        tick(4'b0001, "exh.resume");
        check("exh.resume.cc0", 64'(credit_count[0]), 64'd0);
        clear_reqs();

        // Simultaneous send and return on VC1 at count 3
        for (int c = 0; c < 5; c++) begin
            set_req(2, 1'b1, 1'b1, 1'b1);
            tick(4'b0100, "sim.drain");
        end
        check("sim.cc1.pre", 64'(credit_count[1]), 64'd3);
        set_req(2, 1'b1, 1'b1, 1'b1);
        credit_granted = 2'b10;
        tick(4'b0100, "sim.both");
        check("sim.cc1.both", 64'(credit_count[1]), 64'd3);
        clear_reqs();
        for (int c = 0; c < 5; c++) tick(4'b0000, "sim.refill");
        check("sim.cc1.full", 64'(credit_count[1]), 64'd8);
        check("sim.ovf.pre", 64'(credit_overflow), 64'd0);
        tick(4'b0000, "ovf");
        check("ovf.flag", 64'(credit_overflow), 64'd1);
        check("ovf.cc1", 64'(credit_count[1]), 64'd8);
        credit_granted = 2'b00;
        tick(4'b0000, "ovf.hold");
        check("ovf.sticky", 64'(credit_overflow), 64'd1);

        // Reset in the middle of a 4-flit packet from input 3
        set_req(3, 1'b1, 1'b1, 1'b0);
        tick(4'b1000, "mid1");
        set_req(3, 1'b1, 1'b1, 1'b0);
        tick(4'b1000, "mid2");
        check("mid2.locked", 64'(locked), 64'd1);
        set_req(3, 1'b1, 1'b1, 1'b0);
        n_rst = 1'b0;
        tick(4'b0000, "mid.rst");
        check("mid.rst.locked", 64'(locked), 64'd0);
        check("mid.rst.cc0", 64'(credit_count[0]), 64'd8);
        check("mid.rst.cc1", 64'(credit_count[1]), 64'd8);
        check("mid.rst.ovf", 64'(credit_overflow), 64'd0);
        n_rst = 1'b1;
        set_req(0, 1'b1, 1'b0, 1'b1);
        set_req(3, 1'b1, 1'b1, 1'b0);
        tick(4'b0001, "post.rst0");
        set_req(0, 1'b0, 1'b0, 1'b0);
        tick(4'b1000, "post.rst3");
        check("post.locked", 64'(locked), 64'd1);
        clear_reqs();
        tick(4'b0000, "post.bubble");
        check("post.bubble.locked", 64'(locked), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
